muldiv_seq: RTL and testbench

Iterative multi-cycle MULT/MULTU/DIV/DIVU unit with the architectural HI/LO registers. It sits beside the EX-stage ALU. It accepts one operation from EX, sequences a radix-2 shift-add or restoring-divide datapath over WIDTH cycles, and raises a stall to the hazard logic until HI/LO are valid. It also services MTHI/MTLO writes and MFHI/MFLO reads.

---
 rtl/muldiv_seq.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers: radix-2 shift-add
// multiply and restoring divide, one bit per cycle. Optional macro: MULDIV_EARLY_OUT_EN.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only when the unit is in IDLE (stall low or
  // rising only because of start itself); done pulses once per accepted,
  // unflushed operation on the cycle HI/LO first show the result.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_d;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;       // product, or remainder:quotient
  logic [CNT_W-1:0]   cnt;
  logic               neg_q, rneg_q;

  logic               is_div, is_signed, early;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_tmp;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign dbg_state = state;
  assign stall     = busy | (start & (state == S_IDLE));

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0] rem_cnt;
  assign rem_cnt = CNT_W'(WIDTH) - cnt;
  assign early   = !is_div && (mplier == '0);
`else
  assign early   = 1'b0;
`endif

  assign a_mag = (is_signed && a_q[WIDTH-1]) ? ({WIDTH{1'b0}} - a_q) : a_q;
  assign b_mag = (is_signed && b_q[WIDTH-1]) ? ({WIDTH{1'b0}} - b_q) : b_q;

  // Multiply step: conditional add into the upper half, carry shifts back in.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign mul_next = mplier[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Divide step: the shifted remainder needs WIDTH+1 bits before the trial.
  assign div_tmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = (div_tmp >= {1'b0, opnd});
  assign div_diff = div_tmp[WIDTH-1:0] - opnd;
  assign div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                           : {div_tmp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  assign prod_fix = neg_q ? ({(2*WIDTH){1'b0}} - acc) : acc;

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_q == '0) begin
        res_lo = '1;
        res_hi = a_q;
      end else begin
        res_lo = neg_q  ? ({WIDTH{1'b0}} - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        res_hi = rneg_q ? ({WIDTH{1'b0}} - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (start) state_d = S_PREP;
      S_PREP: state_d = S_RUN;
      S_RUN:  if (cnt == LAST || early) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != S_IDLE);
      done  <= (state == S_FIX) && !flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      opnd   <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
        end
        S_PREP: begin
          opnd   <= is_div ? b_mag : a_mag;
          mplier <= b_mag;
          acc    <= is_div ? {{WIDTH{1'b0}}, a_mag} : '0;
          cnt    <= '0;
          neg_q  <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_q <= is_signed & a_q[WIDTH-1];
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            acc <= acc >> rem_cnt;
          end else
`endif
          if (is_div) begin
            acc <= div_next;
          end else begin
            acc    <= mul_next;
            mplier <= mplier >> 1;
          end
        end
        S_FIX: begin
          if (!flush) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=32); honours MULDIV_EARLY_OUT_EN.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_fail;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drivers: inputs change on negedges, outputs sampled on negedges.
  task automatic issue_start(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // After issue_start: lat = k where done is seen at the negedge after edge E0+k.
  task automatic wait_done(output int lat, output int stall_low);
    lat = -1;
    stall_low = (stall !== 1'b1) ? 1 : 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (stall !== 1'b1) stall_low++;
    end
  endtask

  task automatic mt_write(input logic [31:0] hv, input logic [31:0] lv);
    @(negedge clk);
    hi_we = 1'b1; wdata = hv;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = lv;
    @(negedge clk);
    lo_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #23;
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu_max;
    int lat, sl;
    issue_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, sl);
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL multu_max_latency: got %0d want 34", lat); end
    n_cmp++; if (sl !== 0) begin n_fail++; $display("FAIL multu_max_stall: stall low %0d cycles want 0", sl); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_max_hi: got %h want fffffffe", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_max_lo: got %h want 00000001", lo); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_max_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_signed;
    int lat, sl;
    issue_start(OP_MULT, 32'hFFFF_FFF9, 32'd6);
    wait_done(lat, sl);
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFD6) begin n_fail++; $display("FAIL mult_neg_lo: got %h want ffffffd6", lo); end
    issue_start(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, sl);
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL div_neg_latency: got %0d want 34", lat); end
    n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    issue_start(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB);
    wait_done(lat, sl);
    n_cmp++; if (lo !== 32'd15 || hi !== 32'd0) begin n_fail++; $display("FAIL mult_negneg: got %h_%h want 0_f", hi, lo); end
  endtask

  task automatic test_divide;
    int lat, sl;
    issue_start(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat, sl);
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL divu_latency: got %0d want 34", lat); end
    n_cmp++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL divu_100_7: got hi=%0d lo=%0d want 2/14", hi, lo); end
    issue_start(OP_DIVU, 32'd100, 32'd0);
    wait_done(lat, sl);
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL divu_zero_latency: got %0d want 34", lat); end
    n_cmp++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd100) begin n_fail++; $display("FAIL divu_zero: got hi=%h lo=%h want 64/ffffffff", hi, lo); end
    issue_start(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(lat, sl);
    n_cmp++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL div_zero: got hi=%h lo=%h want fffffff9/ffffffff", hi, lo); end
    issue_start(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, sl);
    n_cmp++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin n_fail++; $display("FAIL div_overflow: got hi=%h lo=%h want 0/80000000", hi, lo); end
    issue_start(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat, sl);
    n_cmp++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin n_fail++; $display("FAIL div_pos_neg: got hi=%h lo=%h want 1/fffffffd", hi, lo); end
  endtask

  task automatic test_flush;
    int ndone;
    mt_write(32'h1234, 32'h5678);
    n_cmp++; if (hi !== 32'h1234 || lo !== 32'h5678) begin n_fail++; $display("FAIL mt_write: got hi=%h lo=%h want 1234/5678", hi, lo); end
    issue_start(OP_DIVU, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL flush_in_run: state %0d want 2", dbg_state); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (dbg_state !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: state=%0d busy=%b want 0/0", dbg_state, busy); end
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_cmp++; if (ndone !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d dones want 0", ndone); end
    n_cmp++; if (hi !== 32'h1234 || lo !== 32'h5678) begin n_fail++; $display("FAIL flush_retain: got hi=%h lo=%h want 1234/5678", hi, lo); end
    // flush in IDLE with start drops the start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_cmp++; if (dbg_state !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_drop_start: state=%0d busy=%b want 0/0", dbg_state, busy); end
  endtask

  task automatic test_back_to_back;
    int ndone;
    logic [31:0] cap_hi, cap_lo;
    issue_start(OP_MULTU, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1; hi_we = 1'b1; wdata = 32'hBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    ndone = 0; cap_hi = '0; cap_lo = '0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin ndone++; cap_hi = hi; cap_lo = lo; end
    end
    n_cmp++; if (ndone !== 1) begin n_fail++; $display("FAIL busy_start_ignored: got %0d dones want 1", ndone); end
    n_cmp++; if (cap_lo !== 32'd63 || cap_hi !== 32'd0) begin n_fail++; $display("FAIL busy_result: got hi=%h lo=%h want 0/3f", cap_hi, cap_lo); end
    n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL busy_mthi_ignored: got %h want 0", hi); end
  endtask

  task automatic test_same_edge;
    int lat, sl;
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5; hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    n_cmp++; if (hi !== 32'hDEAD) begin n_fail++; $display("FAIL same_edge_write: got %h want dead", hi); end
    wait_done(lat, sl);
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd15) begin n_fail++; $display("FAIL same_edge_result: got hi=%h lo=%h want 0/f", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int lat, sl;
    mt_write(32'hAAAA_5555, 32'h5555_AAAA);
    issue_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_mid_busy: busy=%b state=%0d want 0/0", busy, dbg_state); end
    n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_mid_hilo: got hi=%h lo=%h want 0/0", hi, lo); end
    repeat (2) @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_done: got %b want 0", done); end
    rst_n = 1'b1;
    issue_start(OP_MULTU, 32'd3, 32'd5);
    wait_done(lat, sl);
    n_cmp++; if (lat < 3 || lat > 34) begin n_fail++; $display("FAIL reset_mid_latency: got %0d want 3..34", lat); end
    n_cmp++; if (lo !== 32'd15 || hi !== 32'd0) begin n_fail++; $display("FAIL reset_mid_mult: got hi=%h lo=%h want 0/f", hi, lo); end
  endtask

  task automatic test_early_out;
    int lat, sl;
    issue_start(OP_MULTU, 32'd9, 32'd1);
    wait_done(lat, sl);
    n_cmp++; if (lo !== 32'd9 || hi !== 32'd0) begin n_fail++; $display("FAIL mult_9x1: got hi=%h lo=%h want 0/9", hi, lo); end
`ifdef MULDIV_EARLY_OUT_EN
    n_cmp++; if (lat < 3 || lat >= 34) begin n_fail++; $display("FAIL early_9x1_latency: got %0d want 3..33", lat); end
    issue_start(OP_MULTU, 32'd9, 32'd0);
    wait_done(lat, sl);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL early_zero_latency: got %0d want 3", lat); end
`else
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL fixed_9x1_latency: got %0d want 34", lat); end
    issue_start(OP_MULTU, 32'd9, 32'd0);
    wait_done(lat, sl);
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL fixed_zero_latency: got %0d want 34", lat); end
`endif
    n_cmp++; if (lo !== 32'd0 || hi !== 32'd0) begin n_fail++; $display("FAIL mult_by_zero: got hi=%h lo=%h want 0/0", hi, lo); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_multu_max();
    test_signed();
    test_divide();
    test_flush();
    test_back_to_back();
    test_same_edge();
    test_reset_mid();
    test_early_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
